// File: rtl/mux_bus_pkg.sv
// Shared state encoding, default bus timing and sizing helpers for the
// multiplexed address/data bus transfer engine.
package mux_bus_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_A_SETUP = 3'd1;
  localparam logic [2:0] S_A_STB   = 3'd2;
  localparam logic [2:0] S_A_GAP   = 3'd3;
  localparam logic [2:0] S_D_STB   = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NUM_CS = 1;
  localparam int DEF_T_ADS  = 2;
  localparam int DEF_T_STB  = 6;
  localparam int DEF_T_GAP  = 10;
  localparam int DEF_T_REC  = 4;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // The timer holds (phase length - 1), so max_val-1 must fit.
  function automatic int tmr_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/mux_bus_xfer_phase_timer.sv
// Loadable down-counter timing each bus phase; saturates at zero.
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero,
  output logic         zero_next
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign zero      = (count_q == '0);
  assign zero_next = (count_d == '0);

endmodule

// File: rtl/mux_bus_xfer.sv
// Single-transfer engine for a multiplexed address/data bus with per-channel
// chip selects. Every output is a flop loaded from the next-state decode.
module mux_bus_xfer import mux_bus_pkg::*; #(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int NUM_CS = DEF_NUM_CS,
  parameter  int T_ADS  = DEF_T_ADS,
  parameter  int T_STB  = DEF_T_STB,
  parameter  int T_GAP  = DEF_T_GAP,
  parameter  int T_REC  = DEF_T_REC,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rnw,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              ad_n,
  output logic [NUM_CS-1:0] cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_in,
  output logic [2:0]        state_dbg
);

  localparam int TMR_W = tmr_width(max4(T_ADS, T_STB, T_GAP, T_REC));
  localparam logic [CS_W:0] NUM_CS_L = (CS_W + 1)'(NUM_CS);

  if (T_ADS < 1 || T_STB < 1 || T_GAP < 1 || T_REC < 1) begin : g_bad_timing
    $error("mux_bus_xfer: every timing parameter must be at least 1");
  end

  logic [2:0]        state_q, state_d;
  logic              rnw_q, rnw_d;
  logic [CS_W-1:0]   cs_sel_q, cs_sel_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic              ready_q, ready_d, done_q, done_d, err_q, err_d;
  logic              ad_n_q, ad_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic [DATA_W-1:0] bus_out_q, bus_out_d;
  logic              bus_oe_q, bus_oe_d;

  logic              tmr_load, tmr_zero, tmr_zero_next;
  logic [TMR_W-1:0]  tmr_val;
  logic              accept, cs_ok_q, cs_ok_d, addr_phase, strobe, d_write;

  phase_timer #(.W(TMR_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .zero      (tmr_zero),
    .zero_next (tmr_zero_next)
  );

  // Handshake: req is taken on a rising edge where req && ready; ready drops
  // for the whole transfer and any req seen meanwhile is dropped, not queued.
  assign accept  = req & ready_q;
  assign cs_ok_q = ({1'b0, cs_sel_q} < NUM_CS_L);

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    rnw_d    = rnw_q;
    cs_sel_d = cs_sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d  = S_A_SETUP;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(T_ADS - 1);
        rnw_d    = rnw;
        cs_sel_d = cs_sel;
        addr_d   = addr;
        wdata_d  = wdata;
      end
      S_A_SETUP: if (tmr_zero) begin
        state_d  = S_A_STB;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(T_STB - 1);
      end
      S_A_STB: if (tmr_zero) begin
        state_d  = S_A_GAP;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(T_GAP - 1);
      end
      S_A_GAP: if (tmr_zero) begin
        state_d  = S_D_STB;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(T_STB - 1);
      end
      S_D_STB: if (tmr_zero) begin
        state_d  = S_RECOVER;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(T_REC - 1);
        if (rnw_q && cs_ok_q) rdata_d = bus_in;
      end
      S_RECOVER: if (tmr_zero) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from the next state so they are registered yet aligned.
  always_comb begin
    cs_ok_d    = ({1'b0, cs_sel_d} < NUM_CS_L);
    addr_phase = (state_d inside {S_A_SETUP, S_A_STB, S_A_GAP});
    strobe     = (state_d == S_A_STB) || (state_d == S_D_STB);
    d_write    = (state_d == S_D_STB) && !rnw_d;
    ready_d    = (state_d == S_IDLE);
    done_d     = (state_d == S_RECOVER) && tmr_zero_next;
    err_d      = done_d && !cs_ok_d;
    ad_n_d     = !addr_phase;
    wr_n_d     = !((state_d == S_A_STB) || d_write);
    rd_n_d     = !((state_d == S_D_STB) && rnw_d);
    bus_oe_d   = addr_phase || d_write;
    bus_out_d  = addr_phase ? addr_d : (d_write ? wdata_d : '0);
    cs_n_d     = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (strobe && cs_ok_d && (cs_sel_d == CS_W'(i))) cs_n_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rnw_q     <= 1'b0;
      cs_sel_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ad_n_q    <= 1'b1;
      cs_n_q    <= '1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      bus_out_q <= '0;
      bus_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rnw_q     <= rnw_d;
      cs_sel_q  <= cs_sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ad_n_q    <= ad_n_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      bus_out_q <= bus_out_d;
      bus_oe_q  <= bus_oe_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign ad_n      = ad_n_q;
  assign cs_n      = cs_n_q;
  assign rd_n      = rd_n_q;
  assign wr_n      = wr_n_q;
  assign bus_out   = bus_out_q;
  assign bus_oe    = bus_oe_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mux_bus_xfer.sv
// Bench for mux_bus_xfer: a default 8-bit instance and a 16-bit, five-channel
// short-timing instance, both checked every cycle against a phase-window model.
module tb_mux_bus_xfer;
  import mux_bus_pkg::*;

  localparam int A_ADS = 2, A_STB = 6, A_GAP = 10, A_REC = 4, A_NCS = 1;
  // Five channels so cs_sel is 3 bits wide and can carry the out-of-range value 5.
  localparam int B_ADS = 2, B_STB = 1, B_GAP = 1,  B_REC = 4, B_NCS = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_v[2], rnw_v[2];
  logic [2:0]  cs_v[2];
  logic [15:0] addr_v[2], wdata_v[2], bus_in_v[2];

  logic        ready_o[2], done_o[2], err_o[2], ad_n_o[2], rd_n_o[2], wr_n_o[2], bus_oe_o[2];
  logic [15:0] bus_out_o[2], rdata_o[2];
  logic [4:0]  cs_n_o[2];

  logic [7:0]  rdata_a, bus_out_a;
  logic [0:0]  cs_n_a;
  logic [2:0]  st_a, st_b;
  logic [15:0] rdata_b, bus_out_b;
  logic [4:0]  cs_n_b;

  mux_bus_xfer #(.DATA_W(8), .NUM_CS(A_NCS), .T_ADS(A_ADS), .T_STB(A_STB),
                 .T_GAP(A_GAP), .T_REC(A_REC)) dut_a (
    .clk(clk), .reset(reset), .req(req_v[0]), .rnw(rnw_v[0]), .cs_sel(cs_v[0][0:0]),
    .addr(addr_v[0][7:0]), .wdata(wdata_v[0][7:0]), .ready(ready_o[0]), .done(done_o[0]),
    .err(err_o[0]), .rdata(rdata_a), .ad_n(ad_n_o[0]), .cs_n(cs_n_a), .rd_n(rd_n_o[0]),
    .wr_n(wr_n_o[0]), .bus_out(bus_out_a), .bus_oe(bus_oe_o[0]), .bus_in(bus_in_v[0][7:0]),
    .state_dbg(st_a));

  mux_bus_xfer #(.DATA_W(16), .NUM_CS(B_NCS), .T_ADS(B_ADS), .T_STB(B_STB),
                 .T_GAP(B_GAP), .T_REC(B_REC)) dut_b (
    .clk(clk), .reset(reset), .req(req_v[1]), .rnw(rnw_v[1]), .cs_sel(cs_v[1]),
    .addr(addr_v[1]), .wdata(wdata_v[1]), .ready(ready_o[1]), .done(done_o[1]),
    .err(err_o[1]), .rdata(rdata_b), .ad_n(ad_n_o[1]), .cs_n(cs_n_b), .rd_n(rd_n_o[1]),
    .wr_n(wr_n_o[1]), .bus_out(bus_out_b), .bus_oe(bus_oe_o[1]), .bus_in(bus_in_v[1]),
    .state_dbg(st_b));

  assign rdata_o[0]   = {8'h00, rdata_a};
  assign bus_out_o[0] = {8'h00, bus_out_a};
  assign cs_n_o[0]    = {4'hF, cs_n_a};
  assign rdata_o[1]   = rdata_b;
  assign bus_out_o[1] = bus_out_b;
  assign cs_n_o[1]    = cs_n_b;

  int          p_ads[2] = '{A_ADS, B_ADS};
  int          p_stb[2] = '{A_STB, B_STB};
  int          p_gap[2] = '{A_GAP, B_GAP};
  int          p_rec[2] = '{A_REC, B_REC};
  int          p_ncs[2] = '{A_NCS, B_NCS};
  logic [15:0] dw_mask[2] = '{16'h00FF, 16'hFFFF};

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Model: a transfer is a count k of cycles since accept; every output is a
  // pure function of which timing window k falls in.
  bit          m_busy[2];
  int          m_k[2], m_cs[2];
  bit          m_rnw[2];
  logic [15:0] m_addr[2], m_wdata[2], m_rdata[2];

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (reset) begin
        m_busy[j]  <= 1'b0;
        m_k[j]     <= 0;
        m_rdata[j] <= '0;
      end else if (m_busy[j]) begin
        if (m_k[j] == p_ads[j] + 2 * p_stb[j] + p_gap[j] && m_rnw[j] && m_cs[j] < p_ncs[j])
          m_rdata[j] <= bus_in_v[j] & dw_mask[j];
        if (m_k[j] == p_ads[j] + 2 * p_stb[j] + p_gap[j] + p_rec[j]) begin
          m_busy[j] <= 1'b0;
          m_k[j]    <= 0;
        end else begin
          m_k[j] <= m_k[j] + 1;
        end
      end else if (req_v[j]) begin
        m_busy[j]  <= 1'b1;
        m_k[j]     <= 1;
        m_rnw[j]   <= rnw_v[j];
        m_cs[j]    <= (j == 0) ? int'(cs_v[j][0]) : int'(cs_v[j]);
        m_addr[j]  <= addr_v[j] & dw_mask[j];
        m_wdata[j] <= wdata_v[j] & dw_mask[j];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < 2; j++) begin
        int a_end, d_end, len, k;
        bit in_addr, in_astb, in_dstb, cs_ok, e_done, e_oe;
        logic [4:0] e_cs;
        k       = m_busy[j] ? m_k[j] : 0;
        a_end   = p_ads[j] + p_stb[j] + p_gap[j];
        d_end   = a_end + p_stb[j];
        len     = d_end + p_rec[j];
        in_addr = (k >= 1) && (k <= a_end);
        in_astb = (k > p_ads[j]) && (k <= p_ads[j] + p_stb[j]);
        in_dstb = (k > a_end) && (k <= d_end);
        cs_ok   = m_cs[j] < p_ncs[j];
        e_done  = (k == len);
        e_oe    = in_addr || (in_dstb && !m_rnw[j]);
        e_cs    = 5'h1F;
        if ((in_astb || in_dstb) && cs_ok) e_cs[m_cs[j]] = 1'b0;
        check("ready", j, 32'(ready_o[j]), 32'(!m_busy[j]));
        check("done",  j, 32'(done_o[j]),  32'(e_done));
        check("err",   j, 32'(err_o[j]),   32'(e_done && !cs_ok));
        check("ad_n",  j, 32'(ad_n_o[j]),  32'(!in_addr));
        check("wr_n",  j, 32'(wr_n_o[j]),  32'(!(in_astb || (in_dstb && !m_rnw[j]))));
        check("rd_n",  j, 32'(rd_n_o[j]),  32'(!(in_dstb && m_rnw[j])));
        check("cs_n",  j, 32'(cs_n_o[j]),  32'(e_cs));
        check("bus_oe", j, 32'(bus_oe_o[j]), 32'(e_oe));
        if (e_oe) check("bus_out", j, 32'(bus_out_o[j]), 32'(in_addr ? m_addr[j] : m_wdata[j]));
        check("rdata", j, 32'(rdata_o[j]), 32'(m_rdata[j]));
      end
    end
  end

  int          lat_g, ad_lo_g, wr_lo_g, rd_lo_g, cs_lo_g[5];
  bit          err_g;
  logic [15:0] out_first_g, out_last_g;

  task automatic wait_ready(input int i);
    int g = 0;
    while (!ready_o[i] && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("ready_wait", i, 32'(ready_o[i]), 32'd1);
  endtask

  // Runs one transfer and tallies strobe-low cycles from accept up to done.
  task automatic run_xfer(input int i, input bit r, input int cs, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] bi);
    bit seen = 1'b0;
    @(negedge clk);
    wait_ready(i);
    rnw_v[i] = r; cs_v[i] = 3'(cs); addr_v[i] = a; wdata_v[i] = wd; bus_in_v[i] = bi;
    req_v[i] = 1'b1;
    @(negedge clk);
    req_v[i] = 1'b0;
    lat_g = 0; ad_lo_g = 0; wr_lo_g = 0; rd_lo_g = 0; err_g = 1'b0;
    for (int b = 0; b < 5; b++) cs_lo_g[b] = 0;
    while (!seen && lat_g < 200) begin
      lat_g++;
      if (lat_g == 1) out_first_g = bus_out_o[i];
      if (bus_oe_o[i]) out_last_g = bus_out_o[i];
      if (!ad_n_o[i]) ad_lo_g++;
      if (!wr_n_o[i]) wr_lo_g++;
      if (!rd_n_o[i]) rd_lo_g++;
      for (int b = 0; b < 5; b++) if (!cs_n_o[i][b]) cs_lo_g[b]++;
      if (done_o[i]) begin
        seen  = 1'b1;
        err_g = err_o[i];
      end else begin
        @(negedge clk);
      end
    end
    check("xfer_done_seen", i, 32'(seen), 32'd1);
  endtask

  task automatic rand_drive(input int i, input int n);
    repeat (n) begin
      @(negedge clk);
      req_v[i]    = ($urandom_range(0, 3) != 0);
      rnw_v[i]    = 1'($urandom_range(0, 1));
      cs_v[i]     = 3'($urandom_range(0, (i == 0) ? 1 : 7));
      addr_v[i]   = 16'($urandom) & dw_mask[i];
      wdata_v[i]  = 16'($urandom) & dw_mask[i];
      bus_in_v[i] = 16'($urandom) & dw_mask[i];
    end
    @(negedge clk);
    req_v[i] = 1'b0;
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int g, cnt;
    for (int j = 0; j < 2; j++) begin
      req_v[j] = 1'b0; rnw_v[j] = 1'b0; cs_v[j] = '0;
      addr_v[j] = '0; wdata_v[j] = '0; bus_in_v[j] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset_state_a", 0, 32'(st_a), 32'(S_IDLE));
    check("reset_state_b", 1, 32'(st_b), 32'(S_IDLE));
    check("reset_bus_out", 0, 32'(bus_out_o[0]), 32'd0);

    // Default write: addr 0x21, data 0x5A on channel 0.
    run_xfer(0, 1'b0, 0, 16'h0021, 16'h005A, 16'h0000);
    check("wr_latency", 0, 32'(lat_g), 32'd28);
    check("wr_ad_low", 0, 32'(ad_lo_g), 32'd18);
    check("wr_wr_low", 0, 32'(wr_lo_g), 32'd12);
    check("wr_rd_low", 0, 32'(rd_lo_g), 32'd0);
    check("wr_cs0_low", 0, 32'(cs_lo_g[0]), 32'd12);
    check("wr_out_addr", 0, 32'(out_first_g), 32'h21);
    check("wr_out_data", 0, 32'(out_last_g), 32'h5A);
    check("wr_err", 0, 32'(err_g), 32'd0);

    // Default read: addr 0x22, bus returns 0xC3.
    run_xfer(0, 1'b1, 0, 16'h0022, 16'h0000, 16'h00C3);
    check("rd_latency", 0, 32'(lat_g), 32'd28);
    check("rd_rd_low", 0, 32'(rd_lo_g), 32'd6);
    check("rd_wr_low", 0, 32'(wr_lo_g), 32'd6);
    check("rd_last_driven", 0, 32'(out_last_g), 32'h22);
    @(negedge clk);
    check("rd_rdata", 0, 32'(rdata_o[0]), 32'hC3);

    // Out-of-range channel on the single-channel instance.
    run_xfer(0, 1'b1, 1, 16'h0030, 16'h0000, 16'h0077);
    check("bad_cs_err", 0, 32'(err_g), 32'd1);
    check("bad_cs_no_cs", 0, 32'(cs_lo_g[0]), 32'd0);
    check("bad_cs_latency", 0, 32'(lat_g), 32'd28);
    @(negedge clk);
    check("bad_cs_rdata_kept", 0, 32'(rdata_o[0]), 32'hC3);

    // req held high across two transfers.
    wait_ready(0);
    rnw_v[0] = 1'b0; cs_v[0] = '0; addr_v[0] = 16'h0011; wdata_v[0] = 16'h0099;
    req_v[0] = 1'b1;
    g = 0;
    while (!done_o[0] && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("b2b_first_done", 0, 32'(done_o[0]), 32'd1);
    @(negedge clk);
    check("b2b_ready_after_done", 0, 32'(ready_o[0]), 32'd1);
    @(negedge clk);
    check("b2b_second_accept", 0, 32'({ready_o[0], ad_n_o[0]}), 32'd0);
    req_v[0] = 1'b0;
    g = 0;
    while (!done_o[0] && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("b2b_second_done", 0, 32'(done_o[0]), 32'd1);

    // Reset landing in the data strobe.
    @(negedge clk);
    wait_ready(0);
    rnw_v[0] = 1'b0; cs_v[0] = '0; addr_v[0] = 16'h0044; wdata_v[0] = 16'h0055;
    req_v[0] = 1'b1;
    @(negedge clk);
    req_v[0] = 1'b0;
    repeat (19) @(negedge clk);
    check("dstb_wr_n", 0, 32'(wr_n_o[0]), 32'd0);
    check("dstb_ad_n", 0, 32'(ad_n_o[0]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_ready", 0, 32'(ready_o[0]), 32'd1);
    check("rst_strobes", 0, 32'({ad_n_o[0], rd_n_o[0], wr_n_o[0], cs_n_o[0][0]}), 32'hF);
    check("rst_bus_oe", 0, 32'(bus_oe_o[0]), 32'd0);
    check("rst_bus_out", 0, 32'(bus_out_o[0]), 32'd0);
    check("rst_rdata", 0, 32'(rdata_o[0]), 32'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o[0]) cnt++;
    end
    check("rst_no_done", 0, 32'(cnt), 32'd0);

    // 16-bit short-timing instance: channel 2 read, then channel 5 write.
    run_xfer(1, 1'b1, 2, 16'h1357, 16'h0000, 16'hBEEF);
    check("b_rd_latency", 1, 32'(lat_g), 32'd9);
    check("b_rd_cs2_low", 1, 32'(cs_lo_g[2]), 32'd2);
    check("b_rd_other_cs", 1, 32'(cs_lo_g[0] + cs_lo_g[1] + cs_lo_g[3] + cs_lo_g[4]), 32'd0);
    check("b_rd_err", 1, 32'(err_g), 32'd0);
    @(negedge clk);
    check("b_rd_rdata", 1, 32'(rdata_o[1]), 32'hBEEF);
    run_xfer(1, 1'b0, 5, 16'h2468, 16'h1234, 16'hAAAA);
    check("b_bad_cs_err", 1, 32'(err_g), 32'd1);
    check("b_bad_cs_none", 1, 32'(cs_lo_g[0] + cs_lo_g[1] + cs_lo_g[2] + cs_lo_g[3] + cs_lo_g[4]), 32'd0);
    check("b_bad_latency", 1, 32'(lat_g), 32'd9);
    check("b_bad_wr_low", 1, 32'(wr_lo_g), 32'd2);
    check("b_bad_out_data", 1, 32'(out_last_g), 32'h1234);
    @(negedge clk);
    check("b_bad_rdata_kept", 1, 32'(rdata_o[1]), 32'hBEEF);

    fork
      rand_drive(0, 1500);
      rand_drive(1, 1500);
    join
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
